// File: rtl/hart_mailbox.sv
// rtl/hart_mailbox.sv - inter-hart mailbox: one receive FIFO per hart, round-robin SEND arbitration
//
// Purpose: a hart pushes a 32-bit word into any hart's FIFO with a SEND store.
// It pops its own FIFO with a RECV load. A hart that loses SEND arbitration, or
// that targets a full FIFO, is stalled combinationally and retries.
//
// Ports:
//   clk_i           core clock
//   rst_ni          asynchronous active-low reset
//   re_packed_i     per-hart read request (window-qualified)
//   we_packed_i     per-hart write request (window-qualified)
//   addr_packed_i   per-hart byte offset, ADDRW bits per hart
//   wdata_packed_i  per-hart store data, 32 bits per hart
//   rdata_packed_o  per-hart registered read data, 32 bits per hart
//   stall_packed_o  per-hart combinational stall
module hart_mailbox #(
    parameter int NCORES = 3,
    parameter int DEPTH  = 8,
    parameter int ADDRW  = 9
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NCORES-1:0]         re_packed_i,
    input  logic [NCORES-1:0]         we_packed_i,
    input  logic [ADDRW*NCORES-1:0]   addr_packed_i,
    input  logic [32*NCORES-1:0]      wdata_packed_i,
    output logic [32*NCORES-1:0]      rdata_packed_o,
    output logic [NCORES-1:0]         stall_packed_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [ADDRW-1:0] OFF_RECV   = '0;
    localparam logic [ADDRW-1:0] OFF_STATUS = ADDRW'(4);
    localparam logic [ADDRW-1:0] SEND_LO    = ADDRW'(256);
    localparam logic [ADDRW-1:0] SEND_HI    = ADDRW'(256 + 4 * NCORES);

    // FIFO state
    logic [PW-1:0]         r_head  [NCORES];
    logic [PW-1:0]         r_tail  [NCORES];
    logic [CW-1:0]         r_count [NCORES];
    logic [LW-1:0]         r_last  [NCORES];
    logic [31:0]           r_mem   [NCORES][DEPTH];
    logic [32*NCORES-1:0]  r_rdata;

    // Per-hart request decode
    logic [ADDRW-1:0]      w_off       [NCORES];
    logic [LW-1:0]         w_dest      [NCORES];
    logic [NCORES-1:0]     w_is_recv;
    logic [NCORES-1:0]     w_is_status;
    logic [NCORES-1:0]     w_is_send;
    logic [NCORES-1:0]     w_pop;
    logic [NCORES-1:0]     w_won;

    // Per-destination arbitration
    logic [NCORES-1:0]     w_req       [NCORES];
    logic [NCORES-1:0]     w_gnt_vld;
    logic [LW-1:0]         w_gnt_idx   [NCORES];
    logic [NCORES-1:0]     w_push;
    logic [31:0]           w_push_data [NCORES];

    always_comb begin
        for (int h = 0; h < NCORES; h++) begin
            w_off[h]       = addr_packed_i[ADDRW*h +: ADDRW];
            w_is_recv[h]   = (w_off[h] == OFF_RECV);
            w_is_status[h] = (w_off[h] == OFF_STATUS);
            // SEND window only covers destinations that exist; anything past is silently dropped
            w_is_send[h]   = (w_off[h] >= SEND_LO) && (w_off[h] < SEND_HI) && (w_off[h][1:0] == 2'b00);
            w_dest[h]      = LW'(w_off[h][7:2]);
            w_pop[h]       = re_packed_i[h] & w_is_recv[h] & (r_count[h] != '0);
        end
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int d = 0; d < NCORES; d++) begin
            for (int h = 0; h < NCORES; h++) begin
                w_req[d][h] = we_packed_i[h] & w_is_send[h] & (w_dest[h] == LW'(d));
            end

            // Scan cyclically starting just after the last hart granted to this destination
            w_gnt_vld[d] = 1'b0;
            w_gnt_idx[d] = '0;
            for (int k = 1; k <= NCORES; k++) begin
                idx = int'(r_last[d]) + k;
                if (idx >= NCORES) begin
                    idx = idx - NCORES;
                end
                if (!w_gnt_vld[d] && w_req[d][idx]) begin
                    w_gnt_vld[d] = 1'b1;
                    w_gnt_idx[d] = LW'(idx);
                end
            end

            // Eligibility uses the count at cycle start; a concurrent pop does not free a slot
            w_push[d] = w_gnt_vld[d] & (r_count[d] < CW'(DEPTH));

            w_push_data[d] = '0;
            for (int h = 0; h < NCORES; h++) begin
                if (w_gnt_idx[d] == LW'(h)) begin
                    w_push_data[d] = wdata_packed_i[32*h +: 32];
                end
            end
        end

        for (int h = 0; h < NCORES; h++) begin
            w_won[h] = 1'b0;
            for (int d = 0; d < NCORES; d++) begin
                if (w_push[d] && (w_gnt_idx[d] == LW'(h))) begin
                    w_won[h] = 1'b1;
                end
            end
        end
    end

    // Gated by rst_ni so stall drops immediately when reset asserts
    assign stall_packed_o = {NCORES{rst_ni}} & we_packed_i & w_is_send & ~w_won;
    assign rdata_packed_o = r_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < NCORES; d++) begin
                r_head[d]  <= '0;
                r_tail[d]  <= '0;
                r_count[d] <= '0;
                r_last[d]  <= LW'(NCORES - 1);
            end
            r_rdata <= '0;
        end else begin
            for (int d = 0; d < NCORES; d++) begin
                if (w_push[d]) begin
                    r_tail[d] <= r_tail[d] + PW'(1);
                    r_last[d] <= w_gnt_idx[d];
                end
                if (w_pop[d]) begin
                    r_head[d] <= r_head[d] + PW'(1);
                end
                if (w_push[d] && !w_pop[d]) begin
                    r_count[d] <= r_count[d] + CW'(1);
                end else if (!w_push[d] && w_pop[d]) begin
                    r_count[d] <= r_count[d] - CW'(1);
                end
            end

            for (int h = 0; h < NCORES; h++) begin
                if (re_packed_i[h]) begin
                    if (w_is_recv[h]) begin
                        r_rdata[32*h +: 32] <= w_pop[h] ? r_mem[h][r_head[h]] : 32'h0;
                    end else if (w_is_status[h]) begin
                        r_rdata[32*h +: 32] <= {16'h0, 8'(r_count[h]), 7'h0, (r_count[h] != '0)};
                    end else begin
                        r_rdata[32*h +: 32] <= 32'h0;
                    end
                end
            end
        end
    end

    // FIFO storage is intentionally not reset
    always_ff @(posedge clk_i) begin
        for (int d = 0; d < NCORES; d++) begin
            if (w_push[d]) begin
                r_mem[d][r_tail[d]] <= w_push_data[d];
            end
        end
    end

endmodule

// File: tb/tb_hart_mailbox.sv
// tb/tb_hart_mailbox.sv - directed self-checking bench for hart_mailbox
module tb_hart_mailbox;

    localparam int NC = 3;
    localparam int DP = 8;
    localparam int AW = 9;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NC-1:0]     re_packed_i;
    logic [NC-1:0]     we_packed_i;
    logic [AW*NC-1:0]  addr_packed_i;
    logic [32*NC-1:0]  wdata_packed_i;
    logic [32*NC-1:0]  rdata_packed_o;
    logic [NC-1:0]     stall_packed_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    hart_mailbox #(.NCORES(NC), .DEPTH(DP), .ADDRW(AW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .re_packed_i    (re_packed_i),
        .we_packed_i    (we_packed_i),
        .addr_packed_i  (addr_packed_i),
        .wdata_packed_i (wdata_packed_i),
        .rdata_packed_o (rdata_packed_o),
        .stall_packed_o (stall_packed_o)
    );

    task automatic clr();
        re_packed_i    = '0;
        we_packed_i    = '0;
        addr_packed_i  = '0;
        wdata_packed_i = '0;
    endtask

    task automatic set_rd(input int h, input logic [AW-1:0] off);
        re_packed_i[h]            = 1'b1;
        addr_packed_i[AW*h +: AW] = off;
    endtask

    task automatic set_wr(input int h, input logic [AW-1:0] off, input logic [31:0] d);
        we_packed_i[h]             = 1'b1;
        addr_packed_i[AW*h +: AW]  = off;
        wdata_packed_i[32*h +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input int h, input logic [AW-1:0] off, output logic [31:0] v);
        clr();
        set_rd(h, off);
        step();
        v = rdata_packed_o[32*h +: 32];
        clr();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_ni = 1'b0;
        clr();
        #1;
        n_cmp++;
        if (rdata_packed_o !== '0) begin
            n_err++; $display("FAIL reset_rdata got %h want 0", rdata_packed_o);
        end
        n_cmp++;
        if (stall_packed_o !== '0) begin
            n_err++; $display("FAIL reset_stall got %b want 0", stall_packed_o);
        end
        #11 rst_ni = 1'b1;
        for (int h = 0; h < NC; h++) begin
            rd(h, 9'h004, v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_err++; $display("FAIL reset_status h%0d got %h want 0", h, v);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        clr();
        set_wr(0, 9'h104, 32'hDEADBEEF);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL basic_stall got %b want 000", stall_packed_o);
        end
        step();
        clr();
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0000_0101) begin
            n_err++; $display("FAIL basic_status got %h want 00000101", v);
        end
        rd(1, 9'h000, v);
        n_cmp++;
        if (v !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_recv got %h want deadbeef", v);
        end
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL basic_status_empty got %h want 0", v);
        end
    endtask

    task automatic test_full();
        logic [31:0] v;
        for (int i = 1; i <= 8; i++) begin
            clr();
            set_wr(0, 9'h104, i);
            #1;
            n_cmp++;
            if (stall_packed_o[0] !== 1'b0) begin
                n_err++; $display("FAIL full_fill_stall i%0d got %b want 0", i, stall_packed_o[0]);
            end
            step();
        end
        clr();
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0000_0801) begin
            n_err++; $display("FAIL full_status got %h want 00000801", v);
        end
        set_wr(0, 9'h104, 32'd9);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b001) begin
            n_err++; $display("FAIL full_ninth_stall got %b want 001", stall_packed_o);
        end
        step();
        step();
        n_cmp++;
        if (stall_packed_o !== 3'b001) begin
            n_err++; $display("FAIL full_ninth_held got %b want 001", stall_packed_o);
        end
        set_rd(1, 9'h000);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b001) begin
            n_err++; $display("FAIL full_pop_cycle_stall got %b want 001", stall_packed_o);
        end
        step();
        n_cmp++;
        if (rdata_packed_o[63:32] !== 32'd1) begin
            n_err++; $display("FAIL full_first_pop got %h want 1", rdata_packed_o[63:32]);
        end
        re_packed_i[1] = 1'b0;
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL full_after_pop_stall got %b want 000", stall_packed_o);
        end
        step();
        clr();
        for (int i = 2; i <= 9; i++) begin
            rd(1, 9'h000, v);
            n_cmp++;
            if (v !== i) begin
                n_err++; $display("FAIL full_drain i%0d got %h want %h", i, v, i);
            end
        end
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL full_final_status got %h want 0", v);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] v;
        clr();
        for (int h = 0; h < NC; h++) begin
            set_wr(h, 9'h108, h);
        end
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b110) begin
            n_err++; $display("FAIL rr_cycle1 got %b want 110", stall_packed_o);
        end
        step();
        we_packed_i[0] = 1'b0;
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b100) begin
            n_err++; $display("FAIL rr_cycle2 got %b want 100", stall_packed_o);
        end
        step();
        we_packed_i[1] = 1'b0;
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL rr_cycle3 got %b want 000", stall_packed_o);
        end
        step();
        clr();
        for (int i = 0; i < NC; i++) begin
            rd(2, 9'h000, v);
            n_cmp++;
            if (v !== i) begin
                n_err++; $display("FAIL rr_order i%0d got %h want %h", i, v, i);
            end
        end
    endtask

    task automatic test_edge();
        logic [31:0] v;
        clr();
        set_rd(1, 9'h000);
        set_wr(0, 9'h104, 32'h55);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL edge_pushpop_stall got %b want 000", stall_packed_o);
        end
        step();
        n_cmp++;
        if (rdata_packed_o[63:32] !== 32'h0) begin
            n_err++; $display("FAIL edge_empty_pop got %h want 0", rdata_packed_o[63:32]);
        end
        clr();
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0000_0101) begin
            n_err++; $display("FAIL edge_count1 got %h want 00000101", v);
        end
        rd(1, 9'h000, v);
        n_cmp++;
        if (v !== 32'h55) begin
            n_err++; $display("FAIL edge_pushed_word got %h want 55", v);
        end
        set_wr(2, 9'h100, 32'hA5);
        step();
        clr();
        rd(0, 9'h000, v);
        n_cmp++;
        if (v !== 32'hA5) begin
            n_err++; $display("FAIL edge_h0_recv got %h want a5", v);
        end
        set_rd(0, 9'h0F0);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL edge_badread_stall got %b want 000", stall_packed_o);
        end
        step();
        n_cmp++;
        if (rdata_packed_o[31:0] !== 32'h0) begin
            n_err++; $display("FAIL edge_badread_data got %h want 0", rdata_packed_o[31:0]);
        end
        clr();
        set_wr(0, 9'h10C, 32'h77);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL edge_baddest_stall got %b want 000", stall_packed_o);
        end
        step();
        clr();
        for (int h = 0; h < NC; h++) begin
            rd(h, 9'h004, v);
            n_cmp++;
            if (v !== 32'h0) begin
                n_err++; $display("FAIL edge_baddest_status h%0d got %h want 0", h, v);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        clr();
        set_wr(0, 9'h104, 32'h1000);
        step();
        for (int i = 1; i < 20; i++) begin
            clr();
            set_wr(0, 9'h104, 32'h1000 + i);
            set_rd(1, 9'h000);
            #1;
            n_cmp++;
            if (stall_packed_o !== 3'b000) begin
                n_err++; $display("FAIL wrap_stall i%0d got %b want 000", i, stall_packed_o);
            end
            step();
            n_cmp++;
            if (rdata_packed_o[63:32] !== 32'h1000 + i - 1) begin
                n_err++; $display("FAIL wrap_data i%0d got %h want %h", i, rdata_packed_o[63:32], 32'h1000 + i - 1);
            end
        end
        rd(1, 9'h000, v);
        n_cmp++;
        if (v !== 32'h1013) begin
            n_err++; $display("FAIL wrap_last got %h want 1013", v);
        end
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL wrap_count got %h want 0", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            clr();
            set_wr(0, 9'h104, 32'h200 + i);
            step();
        end
        clr();
        rd(1, 9'h000, v);
        n_cmp++;
        if (v !== 32'h200) begin
            n_err++; $display("FAIL rstmid_pre_pop got %h want 200", v);
        end
        for (int i = 0; i < DP; i++) begin
            clr();
            set_wr(2, 9'h100, 32'h300 + i);
            step();
        end
        clr();
        set_wr(2, 9'h100, 32'h308);
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b100) begin
            n_err++; $display("FAIL rstmid_pre_stall got %b want 100", stall_packed_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b000) begin
            n_err++; $display("FAIL rstmid_stall got %b want 000", stall_packed_o);
        end
        n_cmp++;
        if (rdata_packed_o !== '0) begin
            n_err++; $display("FAIL rstmid_rdata got %h want 0", rdata_packed_o);
        end
        clr();
        #2 rst_ni = 1'b1;
        rd(1, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL rstmid_status1 got %h want 0", v);
        end
        rd(0, 9'h004, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++; $display("FAIL rstmid_status0 got %h want 0", v);
        end
        for (int h = 0; h < NC; h++) begin
            set_wr(h, 9'h104, h);
        end
        #1;
        n_cmp++;
        if (stall_packed_o !== 3'b110) begin
            n_err++; $display("FAIL rstmid_first_grant got %b want 110", stall_packed_o);
        end
        step();
        clr();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_round_robin();
        test_edge();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
